sdpram_port_arbiter: RTL

Round-robin arbiter sharing one simple dual-port RAM (write port A, read port B) among N_REQ requesters. Each cycle it grants at most one write, driven onto port A, and one read, driven onto port B. It returns read data to the granted requester one cycle later with a per-requester valid. It sits directly in front of `simple_dual_port_ram` and drives its `sdpram_if` signals.

---
 rtl/sdpram_arb_pkg.sv | 21 ++
 rtl/sdpram_rr_arbiter.sv | 29 ++
 rtl/sdpram_port_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/sdpram_arb_pkg.sv
// Shared constants and types for the simple-dual-port RAM arbiter.
package sdpram_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int AW_DEF    = 10;
    localparam int DW_DEF    = 32;
    localparam int IDX_W     = (N_REQ_DEF > 1) ? $clog2(N_REQ_DEF) : 1;

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic valid;
        idx_t idx;
    } rd_tag_t;

    // Round-robin successor of a granted index, wrapping at n.
    function automatic int rr_next(input int cur, input int n);
        return (cur == n - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/sdpram_rr_arbiter.sv
// One-hot round-robin picker: first candidate at or after the pointer, wrapping.
module sdpram_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] cand,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    // Scan from the pointer; the first hit wins and masks all later ones.
    always_comb begin
        int   j_v;
        logic hit_s;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            j_v        = (int'(ptr) + i) % N_REQ;
            hit_s      = cand[j_v] & ~any;
            grant[j_v] = hit_s;
            idx        = hit_s ? IW'(j_v) : idx;
            any        = any | hit_s;
        end
    end

endmodule

// File: rtl/sdpram_port_arbiter.sv
// Round-robin write/read arbiter in front of a simple dual-port RAM.
// Define SDPRAM_ARB_BYPASS_EN for new-data return on same-cycle same-address write/read.
module sdpram_port_arbiter
    import sdpram_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  we,
    input  logic [N_REQ*AW-1:0] addr,
    input  logic [N_REQ*DW-1:0] wdata,
    output logic [N_REQ-1:0]  gnt,
    output logic [N_REQ-1:0]  rvalid,
    output logic [DW-1:0]     rdata,
    output logic              wena,
    output logic [AW-1:0]     addra,
    output logic [DW-1:0]     dina,
    output logic              renb,
    output logic [AW-1:0]     addrb,
    input  logic [DW-1:0]     doutb
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] wr_cand_s, rd_cand_s, wr_gnt_s, rd_gnt_s;
    logic [IW-1:0]    wr_idx_s, rd_idx_s, wr_ptr_r, rd_ptr_r;
    logic             wr_any_s, rd_any_s;
    rd_tag_t          rd_tag_r;

    assign wr_cand_s = req & we;
    assign rd_cand_s = req & ~we;

    sdpram_rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_wr_arb (
        .cand(wr_cand_s), .ptr(wr_ptr_r), .grant(wr_gnt_s), .idx(wr_idx_s), .any(wr_any_s)
    );

    sdpram_rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rd_arb (
        .cand(rd_cand_s), .ptr(rd_ptr_r), .grant(rd_gnt_s), .idx(rd_idx_s), .any(rd_any_s)
    );

    assign gnt  = wr_gnt_s | rd_gnt_s;
    assign wena = wr_any_s;
    assign renb = rd_any_s;

    // AND-OR mux of the granted requester onto the RAM ports; zero when idle.
    always_comb begin
        addra = '0;
        dina  = '0;
        addrb = '0;
        for (int i = 0; i < N_REQ; i++) begin
            addra = addra | ({AW{wr_gnt_s[i]}} & addr[i*AW +: AW]);
            dina  = dina  | ({DW{wr_gnt_s[i]}} & wdata[i*DW +: DW]);
            addrb = addrb | ({AW{rd_gnt_s[i]}} & addr[i*AW +: AW]);
        end
    end

    // Round-robin pointers and the tag of the read now in flight in the RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            rd_tag_r <= '0;
        end else begin
            wr_ptr_r       <= wr_any_s ? IW'(rr_next(int'(wr_idx_s), N_REQ)) : wr_ptr_r;
            rd_ptr_r       <= rd_any_s ? IW'(rr_next(int'(rd_idx_s), N_REQ)) : rd_ptr_r;
            rd_tag_r.valid <= rd_any_s;
            rd_tag_r.idx   <= idx_t'(rd_idx_s);
        end
    end

    // Return strobe decoded from the registered tag; one-hot or zero.
    always_comb begin
        rvalid = '0;
        rvalid[rd_tag_r.idx] = rd_tag_r.valid;
    end

`ifdef SDPRAM_ARB_BYPASS_EN
    logic          byp_hit_r;
    logic [DW-1:0] byp_data_r;

    // Capture a same-address write so the colliding read returns the new data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byp_hit_r  <= 1'b0;
            byp_data_r <= '0;
        end else begin
            byp_hit_r  <= wr_any_s && rd_any_s && (addra == addrb);
            byp_data_r <= dina;
        end
    end

    // Read data select: bypass register on a collision, otherwise the RAM output.
    always_comb begin
        rdata = rd_tag_r.valid ? (byp_hit_r ? byp_data_r : doutb) : '0;
    end
`else
    // Read data passes straight from the RAM, qualified by the return tag.
    always_comb begin
        rdata = rd_tag_r.valid ? doutb : '0;
    end
`endif

endmodule
